framebuffer_fetch: RTL and testbench

Fetch stage directly upstream of the per-fragment pipeline. Accepts shaded fragments, reads the destination colour, depth and stencil at the fragment's framebuffer index, and forwards each fragment with its destination values attached. An in-flight scoreboard stalls any fragment whose index is still being processed downstream and not yet written back, which removes read-after-write hazards. Throughput is one fragment per cycle when indices do not collide.

---
 rtl/framebuffer_fetch.sv | 188 ++++++++++++++++++
 tb/tb_framebuffer_fetch.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_fetch.sv
// framebuffer_fetch
//   Fetch stage in front of the per-fragment pipeline. Each accepted fragment
//   issues a read of the destination colour/depth/stencil at its framebuffer
//   index. Two cycles later it leaves with the fetched values attached.
//   An in-flight scoreboard holds back any fragment whose index is still
//   waiting for its write-back downstream, which avoids read-after-write
//   hazards.
//
// Ports
//   aclk, reset               clock, synchronous active-high reset
//   s_frag_*                  input fragment stream (valid/ready handshake)
//   fb_ren, fb_raddr          framebuffer read request
//   fb_*_rdata                read data, valid one cycle after fb_ren and
//                             held while fb_ren is low
//   fragmentProcessed         retire pulse, one per fragment processed
//                             downstream
//   m_frag_*                  output fragment stream with destination values
module framebuffer_fetch #(
  parameter int FRAMEBUFFER_INDEX_WIDTH = 14,
  parameter int SCREEN_POS_WIDTH        = 16,
  parameter int DEPTH_WIDTH             = 16,
  parameter int STENCIL_WIDTH           = 4,
  parameter int PIXEL_WIDTH             = 32,
  parameter int INFLIGHT_DEPTH          = 8
) (
  input  logic                               aclk,
  input  logic                               reset,

  input  logic                               s_frag_tvalid,
  output logic                               s_frag_tready,
  input  logic                               s_frag_tlast,
  input  logic                               s_frag_tkeep,
  input  logic [PIXEL_WIDTH-1:0]             s_frag_tcolor,
  input  logic [31:0]                        s_frag_tdepth,
  input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] s_frag_tindex,
  input  logic [SCREEN_POS_WIDTH-1:0]        s_frag_tscreenPosX,
  input  logic [SCREEN_POS_WIDTH-1:0]        s_frag_tscreenPosY,

  output logic                               fb_ren,
  output logic [FRAMEBUFFER_INDEX_WIDTH-1:0] fb_raddr,
  input  logic [PIXEL_WIDTH-1:0]             fb_color_rdata,
  input  logic [DEPTH_WIDTH-1:0]             fb_depth_rdata,
  input  logic [STENCIL_WIDTH-1:0]           fb_stencil_rdata,

  input  logic                               fragmentProcessed,

  output logic                               m_frag_tvalid,
  input  logic                               m_frag_tready,
  output logic                               m_frag_tlast,
  output logic                               m_frag_tkeep,
  output logic [PIXEL_WIDTH-1:0]             m_frag_tcolor,
  output logic [31:0]                        m_frag_tdepth,
  output logic [FRAMEBUFFER_INDEX_WIDTH-1:0] m_frag_tindex,
  output logic [SCREEN_POS_WIDTH-1:0]        m_frag_tscreenPosX,
  output logic [SCREEN_POS_WIDTH-1:0]        m_frag_tscreenPosY,
  output logic [PIXEL_WIDTH-1:0]             m_frag_tdestinationColor,
  output logic [DEPTH_WIDTH-1:0]             m_frag_tdestinationDepth,
  output logic [STENCIL_WIDTH-1:0]           m_frag_tdestinationStencil
);

  localparam int PTR_W = $clog2(INFLIGHT_DEPTH);

  logic ce;
  logic accept;
  logic full;
  logic hazard;
  logic pop;

  // Scoreboard: circular FIFO of {index, keep} for every fragment in flight
  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] sb_index [INFLIGHT_DEPTH];
  logic                               sb_keep  [INFLIGHT_DEPTH];
  logic [PTR_W-1:0]                   wr_ptr;
  logic [PTR_W-1:0]                   rd_ptr;
  logic [PTR_W:0]                     count;
  logic [INFLIGHT_DEPTH-1:0]          entry_live;

  // S1: read issued, waiting for fb_*_rdata
  logic                               s1_valid;
  logic                               s1_last;
  logic                               s1_keep;
  logic [PIXEL_WIDTH-1:0]             s1_color;
  logic [31:0]                        s1_depth;
  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] s1_index;
  logic [SCREEN_POS_WIDTH-1:0]        s1_pos_x;
  logic [SCREEN_POS_WIDTH-1:0]        s1_pos_y;

  always_comb begin
    ce            = ~m_frag_tvalid | m_frag_tready;
    full          = (count == (PTR_W+1)'(INFLIGHT_DEPTH));
    s_frag_tready = ~reset & ce & ~full & ~hazard;
    accept        = s_frag_tvalid & s_frag_tready;
    fb_ren        = accept;
    fb_raddr      = s_frag_tindex;
    pop           = fragmentProcessed & (count != '0);
  end

  // An entry is live when its distance from rd_ptr is below count
  always_comb begin
    entry_live = '0;
    for (int unsigned i = 0; i < INFLIGHT_DEPTH; i++) begin
      entry_live[i] = ({1'b0, PTR_W'(i) - rd_ptr} < count);
    end
  end

  // Compare against registered contents only: an entry retiring this cycle
  // still blocks, giving a one-cycle conservative stall.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < INFLIGHT_DEPTH; i++) begin
      if (entry_live[i] && sb_keep[i] && (sb_index[i] == s_frag_tindex)) begin
        hazard = 1'b1;
      end
    end
    hazard = hazard & s_frag_tkeep;
  end

  always_ff @(posedge aclk) begin
    if (accept) begin
      sb_index[wr_ptr] <= s_frag_tindex;
      sb_keep[wr_ptr]  <= s_frag_tkeep;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      s1_valid                   <= 1'b0;
      s1_last                    <= 1'b0;
      s1_keep                    <= 1'b0;
      s1_color                   <= '0;
      s1_depth                   <= '0;
      s1_index                   <= '0;
      s1_pos_x                   <= '0;
      s1_pos_y                   <= '0;
      m_frag_tvalid              <= 1'b0;
      m_frag_tlast               <= 1'b0;
      m_frag_tkeep               <= 1'b0;
      m_frag_tcolor              <= '0;
      m_frag_tdepth              <= '0;
      m_frag_tindex              <= '0;
      m_frag_tscreenPosX         <= '0;
      m_frag_tscreenPosY         <= '0;
      m_frag_tdestinationColor   <= '0;
      m_frag_tdestinationDepth   <= '0;
      m_frag_tdestinationStencil <= '0;
    end else if (ce) begin
      s1_valid <= accept;
      if (accept) begin
        s1_last  <= s_frag_tlast;
        s1_keep  <= s_frag_tkeep;
        s1_color <= s_frag_tcolor;
        s1_depth <= s_frag_tdepth;
        s1_index <= s_frag_tindex;
        s1_pos_x <= s_frag_tscreenPosX;
        s1_pos_y <= s_frag_tscreenPosY;
      end
      m_frag_tvalid <= s1_valid;
      if (s1_valid) begin
        m_frag_tlast               <= s1_last;
        m_frag_tkeep               <= s1_keep;
        m_frag_tcolor              <= s1_color;
        m_frag_tdepth              <= s1_depth;
        m_frag_tindex              <= s1_index;
        m_frag_tscreenPosX         <= s1_pos_x;
        m_frag_tscreenPosY         <= s1_pos_y;
        m_frag_tdestinationColor   <= fb_color_rdata;
        m_frag_tdestinationDepth   <= fb_depth_rdata;
        m_frag_tdestinationStencil <= fb_stencil_rdata;
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_fetch.sv
// tb_framebuffer_fetch
//   Directed bench for framebuffer_fetch: a behavioural framebuffer answers
//   reads one cycle after fb_ren and holds its output otherwise; write-backs
//   are applied by the bench together with each fragmentProcessed pulse.
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_framebuffer_fetch;

  localparam int IW  = 14;
  localparam int SW  = 16;
  localparam int DW  = 16;
  localparam int STW = 4;
  localparam int PW  = 32;
  localparam int ID  = 8;

  logic           aclk = 1'b0;
  logic           reset;
  logic           s_frag_tvalid;
  logic           s_frag_tready;
  logic           s_frag_tlast;
  logic           s_frag_tkeep;
  logic [PW-1:0]  s_frag_tcolor;
  logic [31:0]    s_frag_tdepth;
  logic [IW-1:0]  s_frag_tindex;
  logic [SW-1:0]  s_frag_tscreenPosX;
  logic [SW-1:0]  s_frag_tscreenPosY;
  logic           fb_ren;
  logic [IW-1:0]  fb_raddr;
  logic [PW-1:0]  fb_color_rdata;
  logic [DW-1:0]  fb_depth_rdata;
  logic [STW-1:0] fb_stencil_rdata;
  logic           fragmentProcessed;
  logic           m_frag_tvalid;
  logic           m_frag_tready;
  logic           m_frag_tlast;
  logic           m_frag_tkeep;
  logic [PW-1:0]  m_frag_tcolor;
  logic [31:0]    m_frag_tdepth;
  logic [IW-1:0]  m_frag_tindex;
  logic [SW-1:0]  m_frag_tscreenPosX;
  logic [SW-1:0]  m_frag_tscreenPosY;
  logic [PW-1:0]  m_frag_tdestinationColor;
  logic [DW-1:0]  m_frag_tdestinationDepth;
  logic [STW-1:0] m_frag_tdestinationStencil;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0]  mem_c [2**IW];
  logic [DW-1:0]  mem_d [2**IW];
  logic [STW-1:0] mem_s [2**IW];

  framebuffer_fetch #(
    .FRAMEBUFFER_INDEX_WIDTH(IW),
    .SCREEN_POS_WIDTH(SW),
    .DEPTH_WIDTH(DW),
    .STENCIL_WIDTH(STW),
    .PIXEL_WIDTH(PW),
    .INFLIGHT_DEPTH(ID)
  ) dut (
    .aclk(aclk),
    .reset(reset),
    .s_frag_tvalid(s_frag_tvalid),
    .s_frag_tready(s_frag_tready),
    .s_frag_tlast(s_frag_tlast),
    .s_frag_tkeep(s_frag_tkeep),
    .s_frag_tcolor(s_frag_tcolor),
    .s_frag_tdepth(s_frag_tdepth),
    .s_frag_tindex(s_frag_tindex),
    .s_frag_tscreenPosX(s_frag_tscreenPosX),
    .s_frag_tscreenPosY(s_frag_tscreenPosY),
    .fb_ren(fb_ren),
    .fb_raddr(fb_raddr),
    .fb_color_rdata(fb_color_rdata),
    .fb_depth_rdata(fb_depth_rdata),
    .fb_stencil_rdata(fb_stencil_rdata),
    .fragmentProcessed(fragmentProcessed),
    .m_frag_tvalid(m_frag_tvalid),
    .m_frag_tready(m_frag_tready),
    .m_frag_tlast(m_frag_tlast),
    .m_frag_tkeep(m_frag_tkeep),
    .m_frag_tcolor(m_frag_tcolor),
    .m_frag_tdepth(m_frag_tdepth),
    .m_frag_tindex(m_frag_tindex),
    .m_frag_tscreenPosX(m_frag_tscreenPosX),
    .m_frag_tscreenPosY(m_frag_tscreenPosY),
    .m_frag_tdestinationColor(m_frag_tdestinationColor),
    .m_frag_tdestinationDepth(m_frag_tdestinationDepth),
    .m_frag_tdestinationStencil(m_frag_tdestinationStencil)
  );

  always #5 aclk = ~aclk;

  // Framebuffer read port: registered, holds while fb_ren is low
  always @(posedge aclk) begin
    if (fb_ren) begin
      fb_color_rdata   <= mem_c[fb_raddr];
      fb_depth_rdata   <= mem_d[fb_raddr];
      fb_stencil_rdata <= mem_s[fb_raddr];
    end
  end

  function automatic logic [PW-1:0] dflt_c(input int idx);
    return 32'hDEAD0000 | PW'(idx);
  endfunction
  function automatic logic [DW-1:0] dflt_d(input int idx);
    return DW'(idx) ^ 16'h00F0;
  endfunction
  function automatic logic [STW-1:0] dflt_s(input int idx);
    return STW'(idx);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
  endtask

  // Source fields are derived from the index so every output field is known
  task automatic drive(input bit v, input int idx, input bit keep, input bit last);
    s_frag_tvalid      = v;
    s_frag_tindex      = IW'(idx);
    s_frag_tkeep       = keep;
    s_frag_tlast       = last;
    s_frag_tcolor      = 32'hC0DE0000 | PW'(idx);
    s_frag_tdepth      = 32'hFFFF8000 | 32'(idx);
    s_frag_tscreenPosX = SW'(idx + 100);
    s_frag_tscreenPosY = SW'(idx + 200);
  endtask

  task automatic chk_out(input string tag, input int idx, input bit keep, input bit last,
                         input logic [PW-1:0] dc, input logic [DW-1:0] dd,
                         input logic [STW-1:0] ds);
    chk({tag, "_valid"}, m_frag_tvalid, 1'b1);
    chk({tag, "_index"}, m_frag_tindex, IW'(idx));
    chk({tag, "_color"}, m_frag_tcolor, 32'hC0DE0000 | PW'(idx));
    chk({tag, "_depth"}, m_frag_tdepth, 32'hFFFF8000 | 32'(idx));
    chk({tag, "_posx"},  m_frag_tscreenPosX, SW'(idx + 100));
    chk({tag, "_posy"},  m_frag_tscreenPosY, SW'(idx + 200));
    chk({tag, "_keep"},  m_frag_tkeep, keep);
    chk({tag, "_last"},  m_frag_tlast, last);
    chk({tag, "_dcolor"}, m_frag_tdestinationColor, dc);
    chk({tag, "_ddepth"}, m_frag_tdestinationDepth, dd);
    chk({tag, "_dsten"},  m_frag_tdestinationStencil, ds);
  endtask

  task automatic retire(input int n);
    for (int k = 0; k < n; k++) begin
      fragmentProcessed = 1'b1;
      tick();
      fragmentProcessed = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 2**IW; i++) begin
      mem_c[i] = dflt_c(i);
      mem_d[i] = dflt_d(i);
      mem_s[i] = dflt_s(i);
    end
    for (int i = 0; i < 4; i++) mem_c[i] = 32'h11223344 + PW'(i);
    fb_color_rdata    = '0;
    fb_depth_rdata    = '0;
    fb_stencil_rdata  = '0;
    reset             = 1'b1;
    m_frag_tready     = 1'b1;
    fragmentProcessed = 1'b0;
    drive(1, 7, 1, 0);

    // Reset: no ready / no read even with a valid input
    tick(); #1;
    chk("rst_tready", s_frag_tready, 1'b0);
    chk("rst_fbren", fb_ren, 1'b0);
    tick();
    chk("rst_mvalid", m_frag_tvalid, 1'b0);
    chk("rst_count", dut.count, 0);
    chk("rst_mcolor", m_frag_tcolor, 0);
    reset = 1'b0;
    drive(0, 0, 0, 0);

    // Four back-to-back fragments, indices 0..3, latency 2
    tick(); drive(1, 0, 1, 0); #1;
    chk("p1_ready0", s_frag_tready, 1'b1);
    chk("p1_fbren0", fb_ren, 1'b1);
    chk("p1_raddr0", fb_raddr, 0);
    tick(); drive(1, 1, 1, 0); #1;
    chk("p1_ready1", s_frag_tready, 1'b1);
    chk("p1_raddr1", fb_raddr, 1);
    tick(); drive(1, 2, 1, 0); #1;
    chk_out("p1_f0", 0, 1, 0, 32'h11223344, dflt_d(0), dflt_s(0));
    tick(); drive(1, 3, 1, 1); #1;
    chk_out("p1_f1", 1, 1, 0, 32'h11223345, dflt_d(1), dflt_s(1));
    tick(); drive(0, 0, 0, 0); #1;
    chk_out("p1_f2", 2, 1, 0, 32'h11223346, dflt_d(2), dflt_s(2));
    tick();
    chk_out("p1_f3", 3, 1, 1, 32'h11223347, dflt_d(3), dflt_s(3));
    tick();
    chk("p1_idle", m_frag_tvalid, 1'b0);
    chk("p1_count", dut.count, 4);
    retire(4);
    chk("p1_drain", dut.count, 0);

    // Index 5 twice, keep=1: second stalls until the cycle after retire
    drive(1, 5, 1, 0); #1;
    chk("p2_ready_a", s_frag_tready, 1'b1);
    tick(); drive(1, 5, 1, 0); #1;
    chk("p2_haz_ready", s_frag_tready, 1'b0);
    chk("p2_haz_fbren", fb_ren, 1'b0);
    tick(); #1;
    chk("p2_haz_ready2", s_frag_tready, 1'b0);
    chk_out("p2_a", 5, 1, 0, dflt_c(5), dflt_d(5), dflt_s(5));
    tick();
    fragmentProcessed = 1'b1;
    mem_c[5] = 32'hAABBCCDD;
    mem_d[5] = 16'h1234;
    mem_s[5] = 4'h9;
    #1;
    chk("p2_pulse_ready", s_frag_tready, 1'b0);
    tick();
    fragmentProcessed = 1'b0;
    #1;
    chk("p2_release_ready", s_frag_tready, 1'b1);
    chk("p2_release_fbren", fb_ren, 1'b1);
    tick(); drive(0, 0, 0, 0);
    tick();
    chk_out("p2_b", 5, 1, 0, 32'hAABBCCDD, 16'h1234, 4'h9);
    retire(1);

    // Index 6 twice, second keep=0: no stall
    drive(1, 6, 1, 0); #1;
    chk("p3_ready_a", s_frag_tready, 1'b1);
    tick(); drive(1, 6, 0, 0); #1;
    chk("p3_keep0_ready", s_frag_tready, 1'b1);
    chk("p3_keep0_fbren", fb_ren, 1'b1);
    tick(); drive(0, 0, 0, 0); #1;
    chk_out("p3_a", 6, 1, 0, dflt_c(6), dflt_d(6), dflt_s(6));
    tick();
    chk_out("p3_b", 6, 0, 0, dflt_c(6), dflt_d(6), dflt_s(6));
    retire(2);
    chk("p3_drain", dut.count, 0);

    // Fill the scoreboard, ninth fragment waits for one retire
    for (int k = 0; k < 8; k++) begin
      drive(1, 16 + k, 1, 0); #1;
      chk("p4_fill_ready", s_frag_tready, 1'b1);
      tick();
    end
    drive(1, 24, 1, 0); #1;
    chk("p4_full_ready", s_frag_tready, 1'b0);
    chk("p4_full_count", dut.count, 8);
    tick(); #1;
    chk("p4_full_ready2", s_frag_tready, 1'b0);
    fragmentProcessed = 1'b1; #1;
    chk("p4_pulse_ready", s_frag_tready, 1'b0);
    tick();
    fragmentProcessed = 1'b0; #1;
    chk("p4_release_ready", s_frag_tready, 1'b1);
    tick(); drive(0, 0, 0, 0); #1;
    chk("p4_count_after", dut.count, 8);
    tick();
    chk_out("p4_ninth", 24, 1, 0, dflt_c(24), dflt_d(24), dflt_s(24));
    retire(8);
    chk("p4_drain", dut.count, 0);

    // Backpressure for three cycles mid-stream
    drive(1, 30, 1, 0);
    tick(); drive(1, 31, 1, 0);
    tick(); drive(1, 32, 1, 0); m_frag_tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("p5_bp_ready", s_frag_tready, 1'b0);
      chk("p5_bp_fbren", fb_ren, 1'b0);
      chk_out("p5_bp_a", 30, 1, 0, dflt_c(30), dflt_d(30), dflt_s(30));
      tick();
    end
    m_frag_tready = 1'b1; #1;
    chk("p5_resume_ready", s_frag_tready, 1'b1);
    chk("p5_resume_fbren", fb_ren, 1'b1);
    chk_out("p5_a", 30, 1, 0, dflt_c(30), dflt_d(30), dflt_s(30));
    tick(); drive(1, 33, 1, 1); #1;
    chk_out("p5_b", 31, 1, 0, dflt_c(31), dflt_d(31), dflt_s(31));
    tick(); drive(0, 0, 0, 0); #1;
    chk_out("p5_c", 32, 1, 0, dflt_c(32), dflt_d(32), dflt_s(32));
    tick();
    chk_out("p5_d", 33, 1, 1, dflt_c(33), dflt_d(33), dflt_s(33));
    tick();
    chk("p5_idle", m_frag_tvalid, 1'b0);
    retire(4);

    // Reset with two fragments in the pipe and five in flight
    for (int k = 0; k < 5; k++) begin
      drive(1, 40 + k, 1, 0);
      tick();
    end
    drive(1, 50, 1, 0);
    reset = 1'b1; #1;
    chk("p6_rst_ready", s_frag_tready, 1'b0);
    chk("p6_rst_fbren", fb_ren, 1'b0);
    chk("p6_pre_count", dut.count, 5);
    chk("p6_pre_mvalid", m_frag_tvalid, 1'b1);
    chk("p6_pre_index", m_frag_tindex, 43);
    tick();
    reset = 1'b0; #1;
    chk("p6_mvalid", m_frag_tvalid, 1'b0);
    chk("p6_count", dut.count, 0);
    chk("p6_mindex", m_frag_tindex, 0);
    chk("p6_mdcolor", m_frag_tdestinationColor, 0);
    chk("p6_mkeep", m_frag_tkeep, 1'b0);
    chk("p6_ready", s_frag_tready, 1'b1);
    chk("p6_fbren", fb_ren, 1'b1);
    tick(); drive(0, 0, 0, 0); #1;
    chk("p6_count1", dut.count, 1);
    chk("p6_no_stale", m_frag_tvalid, 1'b0);
    tick();
    chk_out("p6_f", 50, 1, 0, dflt_c(50), dflt_d(50), dflt_s(50));
    retire(1);
    chk("p6_drain", dut.count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run always ends on its own
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its end, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
